// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MDU_CYCLES_DEF = 32;

  typedef struct packed {
    logic pc_stall;
    logic if_stall;
    logic if_flush;
    logic id_stall;
    logic ex_stall;
    logic m_stall;
    logic ex_flush;
    logic m_flush;
    logic wb_flush;
  } stall_flush_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stall/flush controls between pipeline and controller
interface pipeline_hazard_ctrl_if;

  logic       IC_Miss;
  logic       DM_Stall;
  logic       EX_MemRead;
  logic [4:0] EX_Rt;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       ID_MduStart;
  logic       ID_MduRead;
  logic       ID_Eret;
  logic       ID_BLikelyNotTaken;
  logic       M_Exception;

  logic       PC_Stall;
  logic       IF_Stall;
  logic       IF_Flush;
  logic       ID_Stall;
  logic       EX_Stall;
  logic       M_Stall;
  logic       EX_Flush;
  logic       M_Flush;
  logic       WB_Flush;
  logic       MDU_Busy;

  modport master (
    output IC_Miss, DM_Stall, EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
           ID_MduStart, ID_MduRead, ID_Eret, ID_BLikelyNotTaken, M_Exception,
    input  PC_Stall, IF_Stall, IF_Flush, ID_Stall, EX_Stall, M_Stall,
           EX_Flush, M_Flush, WB_Flush, MDU_Busy
  );

  modport slave (
    input  IC_Miss, DM_Stall, EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
           ID_MduStart, ID_MduRead, ID_Eret, ID_BLikelyNotTaken, M_Exception,
    output PC_Stall, IF_Stall, IF_Flush, ID_Stall, EX_Stall, M_Stall,
           EX_Flush, M_Flush, WB_Flush, MDU_Busy
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mdu.sv
// rtl/pipeline_hazard_ctrl_mdu.sv - multiply/divide busy counter, loaded on issue and counted down to idle
module mdu_busy_counter #(
  parameter  int CYCLES = 32,
  localparam int W      = $clog2(CYCLES + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  output logic [W-1:0] count,
  output logic         busy
);

  // The issue cycle is the first MDU cycle, so only CYCLES-1 remain afterwards.
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - priority stall/flush controller for the five-stage pipeline
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input logic                  CLK,
  input logic                  RST,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CW = $clog2(MDU_CYCLES + 1);

  logic [CW-1:0] mdu_count;
  logic          mdu_busy;
  logic          exc_pending;
  logic          lu, mh, xf, mdu_accept;
  stall_flush_t  ctl;

  assign lu = hz.EX_MemRead && (hz.EX_Rt != REG_ZERO) &&
              ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_Rt)) ||
               (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_Rt)));
  assign mh = (hz.ID_MduRead || hz.ID_MduStart) && (mdu_count != '0);
  assign xf = (hz.M_Exception || exc_pending) && !hz.DM_Stall;

  assign mdu_accept = hz.ID_MduStart && (mdu_count == '0) && !hz.DM_Stall && !xf && !lu;

  mdu_busy_counter #(.CYCLES(MDU_CYCLES)) u_mdu (
    .CLK  (CLK),
    .RST  (RST),
    .load (mdu_accept),
    .count(mdu_count),
    .busy (mdu_busy)
  );

  // An exception seen while M is held waits here until memory releases it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exc_pending <= 1'b0;
    end else if (hz.M_Exception && hz.DM_Stall) begin
      exc_pending <= 1'b1;
    end else if (xf) begin
      exc_pending <= 1'b0;
    end
  end

  always_comb begin
    ctl = '0;
    if (hz.DM_Stall) begin
      ctl.pc_stall = 1'b1;
      ctl.id_stall = 1'b1;
      ctl.ex_stall = 1'b1;
      ctl.m_stall  = 1'b1;
      ctl.wb_flush = 1'b1;
    end else if (xf) begin
      ctl.if_flush = 1'b1;
      ctl.ex_flush = 1'b1;
      ctl.m_flush  = 1'b1;
      ctl.wb_flush = 1'b1;
    end else if (lu || mh) begin
      ctl.pc_stall = 1'b1;
      ctl.id_stall = 1'b1;
      ctl.ex_flush = 1'b1;
    end else if (hz.ID_Eret || hz.ID_BLikelyNotTaken) begin
      ctl.if_flush = 1'b1;
    end
    if (hz.IC_Miss) begin
      ctl.if_stall = 1'b1;
      ctl.pc_stall = 1'b1;
    end
    if (!RST) begin
      ctl = '0;
    end
  end

  assign hz.PC_Stall = ctl.pc_stall;
  assign hz.IF_Stall = ctl.if_stall;
  assign hz.IF_Flush = ctl.if_flush;
  assign hz.ID_Stall = ctl.id_stall;
  assign hz.EX_Stall = ctl.ex_stall;
  assign hz.M_Stall  = ctl.m_stall;
  assign hz.EX_Flush = ctl.ex_flush;
  assign hz.M_Flush  = ctl.m_flush;
  assign hz.WB_Flush = ctl.wb_flush;
  assign hz.MDU_Busy = mdu_busy && RST;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MDU_N = 4;
  localparam int B_PC = 9, B_IFS = 8, B_IFF = 7, B_IDS = 6, B_EXS = 5;
  localparam int B_MS = 4, B_EXF = 3, B_MF = 2, B_WBF = 1, B_BUSY = 0;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.MDU_CYCLES(MDU_N)) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (hz)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mdu_free = 0;   // first cycle index at which the MDU is idle again
  bit exc_owed = 0;
  logic [9:0] obs_v, exp_v;

  function automatic bit m_lu();
    return hz.EX_MemRead && hz.EX_Rt != 5'd0 &&
           ((hz.ID_UsesRs && hz.ID_Rs == hz.EX_Rt) || (hz.ID_UsesRt && hz.ID_Rt == hz.EX_Rt));
  endfunction

  function automatic bit m_xf();
    return (hz.M_Exception || exc_owed) && !hz.DM_Stall;
  endfunction

  function automatic logic [9:0] model_out();
    logic [9:0] v;
    bit busy;
    v = '0;
    if (!RST) return v;
    busy = cyc < mdu_free;
    v[B_BUSY] = busy;
    if (hz.DM_Stall) begin
      v[B_PC] = 1; v[B_IDS] = 1; v[B_EXS] = 1; v[B_MS] = 1; v[B_WBF] = 1;
    end else if (m_xf()) begin
      v[B_IFF] = 1; v[B_EXF] = 1; v[B_MF] = 1; v[B_WBF] = 1;
    end else if (m_lu() || ((hz.ID_MduRead || hz.ID_MduStart) && busy)) begin
      v[B_PC] = 1; v[B_IDS] = 1; v[B_EXF] = 1;
    end else if (hz.ID_Eret || hz.ID_BLikelyNotTaken) begin
      v[B_IFF] = 1;
    end
    if (hz.IC_Miss) begin
      v[B_IFS] = 1; v[B_PC] = 1;
    end
    return v;
  endfunction

  task automatic model_advance();
    bit busy, xf;
    if (!RST) begin
      mdu_free = 0;
      exc_owed = 0;
    end else begin
      busy = cyc < mdu_free;
      xf   = m_xf();
      if (hz.ID_MduStart && !busy && !hz.DM_Stall && !xf && !m_lu()) mdu_free = cyc + MDU_N;
      if (hz.M_Exception && hz.DM_Stall) exc_owed = 1;
      else if (xf) exc_owed = 0;
    end
    cyc++;
  endtask

  task automatic sample();
    obs_v = {hz.PC_Stall, hz.IF_Stall, hz.IF_Flush, hz.ID_Stall, hz.EX_Stall,
             hz.M_Stall, hz.EX_Flush, hz.M_Flush, hz.WB_Flush, hz.MDU_Busy};
  endtask

  task automatic step(input string tag);
    #1;
    exp_v = model_out();
    sample();
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs_v, exp_v);
    end
    @(posedge CLK);
    model_advance();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.IC_Miss = 0; hz.DM_Stall = 0; hz.EX_MemRead = 0; hz.EX_Rt = 0;
    hz.ID_Rs = 0; hz.ID_Rt = 0; hz.ID_UsesRs = 0; hz.ID_UsesRt = 0;
    hz.ID_MduStart = 0; hz.ID_MduRead = 0; hz.ID_Eret = 0;
    hz.ID_BLikelyNotTaken = 0; hz.M_Exception = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'd3;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nf;
    idle_inputs();
    @(negedge CLK);
    step("reset_hold");
    RST = 1;
    step("idle");

    // load-use: one bubble, then gone; r0 never hazards
    hz.EX_MemRead = 1; hz.EX_Rt = 8; hz.ID_UsesRs = 1; hz.ID_Rs = 8;
    step("lu_hit");
    chk("lu_stall", int'(obs_v[B_IDS] & obs_v[B_PC] & obs_v[B_EXF]), 1);
    hz.EX_MemRead = 0;
    step("lu_after");
    chk("lu_one_bubble", int'(obs_v[B_IDS]), 0);
    hz.EX_MemRead = 1; hz.EX_Rt = 0; hz.ID_Rs = 0;
    step("lu_rzero");
    chk("lu_rzero_nostall", int'(obs_v[B_IDS]), 0);
    idle_inputs();

    // MULT then MFHI held
    hz.ID_MduStart = 1;
    step("mdu_start");
    hz.ID_MduStart = 0; hz.ID_MduRead = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step("mfhi_wait");
      n += int'(obs_v[B_IDS]);
      if (!obs_v[B_IDS]) break;
    end
    chk("mfhi_stall_cycles", n, MDU_N - 1);
    chk("mfhi_release_busy", int'(obs_v[B_BUSY]), 0);
    hz.ID_MduRead = 0; hz.ID_MduStart = 1;
    step("mdu_start2");
    step("mdu_start_busy");
    chk("start_while_busy_stall", int'(obs_v[B_IDS]), 1);
    idle_inputs();
    for (int i = 0; i < MDU_N; i++) step("mdu_drain");

    // exception raised during a 3-cycle memory wait
    hz.DM_Stall = 1; hz.M_Exception = 1;
    n = 0; nf = 0;
    for (int i = 0; i < 3; i++) begin
      step("dm_wait");
      hz.M_Exception = 0;
      n += int'(obs_v[B_MS] & obs_v[B_EXS] & obs_v[B_IDS]);
    end
    hz.DM_Stall = 0;
    for (int i = 0; i < 3; i++) begin
      step("exc_fire");
      nf += int'(obs_v[B_IFF] & obs_v[B_EXF] & obs_v[B_MF] & obs_v[B_WBF]);
    end
    chk("dm_stall_cycles", n, 3);
    chk("exc_flush_once", nf, 1);

    // ERET alone, then ERET behind a load-use
    hz.ID_Eret = 1;
    step("eret");
    chk("eret_flush", int'({obs_v[B_IFF], obs_v[B_IDS]}), 2);
    hz.EX_MemRead = 1; hz.EX_Rt = 9; hz.ID_UsesRt = 1; hz.ID_Rt = 9;
    step("eret_lu");
    chk("eret_lu_hold", int'({obs_v[B_IFF], obs_v[B_IDS]}), 1);
    hz.EX_MemRead = 0;
    step("eret_lu_clear");
    chk("eret_after_lu", int'(obs_v[B_IFF]), 1);
    idle_inputs();

    hz.IC_Miss = 1; hz.ID_BLikelyNotTaken = 1;
    step("icmiss_bl");
    chk("icmiss_bl", int'({obs_v[B_IFS], obs_v[B_IFF], obs_v[B_PC]}), 7);
    idle_inputs();

    // asynchronous reset with MDU counting and an exception pending
    hz.ID_MduStart = 1;
    step("ar_start");
    hz.ID_MduStart = 0; hz.DM_Stall = 1; hz.M_Exception = 1;
    step("ar_exc");
    hz.M_Exception = 0;
    RST = 0;
    #1;
    sample();
    chk("async_reset_zero", int'(obs_v), 0);
    mdu_free = 0; exc_owed = 0;
    #1;
    RST = 1;
    idle_inputs();
    #1;
    sample();
    chk("reset_busy_cleared", int'(obs_v[B_BUSY]), 0);
    step("post_reset");
    chk("post_reset_noflush", int'(obs_v), 0);
    step("post_reset2");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      hz.IC_Miss            = ($urandom_range(0, 7) == 0);
      hz.DM_Stall           = ($urandom_range(0, 5) == 0);
      hz.EX_MemRead         = ($urandom_range(0, 2) == 0);
      hz.EX_Rt              = pick_reg();
      hz.ID_Rs              = pick_reg();
      hz.ID_Rt              = pick_reg();
      hz.ID_UsesRs          = $urandom_range(0, 1);
      hz.ID_UsesRt          = $urandom_range(0, 1);
      hz.ID_MduStart        = ($urandom_range(0, 9) == 0);
      hz.ID_MduRead         = ($urandom_range(0, 5) == 0);
      hz.ID_Eret            = ($urandom_range(0, 15) == 0);
      hz.ID_BLikelyNotTaken = ($urandom_range(0, 15) == 0);
      hz.M_Exception        = ($urandom_range(0, 11) == 0);
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
